// File: rtl/reg_arb2.sv
// Round-robin arbiter sharing a single-port register file between requesters A and B.
// Each grant is one service cycle followed by a registered ack pulse carrying the pre-write data.
module reg_arb2 #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_wr,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_wr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_dati,
    input  logic [DW-1:0] rf_dato,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, SERV_A, SERV_B} state_t;

    state_t state, state_nxt;
    logic   last;  // 0 = A served last, 1 = B served last
    logic   a_eff, b_eff;

    // A requester is not eligible in its own ack cycle, so a held req is not re-granted early.
    assign a_eff = a_req & ~a_ack;
    assign b_eff = b_req & ~b_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            state <= state_nxt;
            a_ack <= (state == SERV_A);
            b_ack <= (state == SERV_B);
            if (state == SERV_A) begin
                a_rdata <= rf_dato;
                last    <= 1'b0;
            end
            if (state == SERV_B) begin
                b_rdata <= rf_dato;
                last    <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (a_eff && b_eff) state_nxt = last ? SERV_A : SERV_B;
                else if (a_eff)     state_nxt = SERV_A;
                else if (b_eff)     state_nxt = SERV_B;
                else                state_nxt = IDLE;
            end
            // The other side's raw req is used here: its ack, if any, belongs to an older access.
            SERV_A:  state_nxt = b_req ? SERV_B : IDLE;
            SERV_B:  state_nxt = a_req ? SERV_A : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_dati = '0;
        busy    = 1'b0;
        case (state)
            SERV_A: begin
                rf_we   = a_wr;
                rf_addr = a_addr;
                rf_dati = a_wdata;
                busy    = 1'b1;
            end
            SERV_B: begin
                rf_we   = b_wr;
                rf_addr = b_addr;
                rf_dati = b_wdata;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_arb2.sv
// Scoreboard bench for reg_arb2: stimulus pushes expected rdata (and optionally the ack cycle),
// a negedge monitor pops and compares on every ack.
module tb_reg_arb2;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ack, b_ack, rf_we, busy;
    logic [DW-1:0] a_rdata, b_rdata, rf_dati, rf_dato;
    logic [AW-1:0] rf_addr;

    reg_arb2 #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_dati(rf_dati), .rf_dato(rf_dato),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file the arbiter sits in front of; cleared by the same reset.
    logic [DW-1:0] rf_mem [16];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_dati;
        end
    end
    assign rf_dato = rf_mem[rf_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            issue;
        int            due;
    } exp_t;

    exp_t          q_a[$];
    exp_t          q_b[$];
    logic [DW-1:0] ref_mem [16];
    int            n_pass = 0;
    int            n_tot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: all comparisons happen here, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_state", int'({a_ack, b_ack, a_rdata, b_rdata, busy, rf_we, rf_addr, rf_dati}), 0);
            end else begin
                if (!busy) chk("idle_rf_outputs", int'({rf_we, rf_addr, rf_dati}), 0);
                if (a_ack || b_ack) chk("ack_overlap", int'(a_ack & b_ack), 0);
                if (a_ack) begin
                    if (q_a.size() == 0) chk("a_ack_pending", q_a.size(), 1);
                    else begin
                        e = q_a.pop_front();
                        chk("a_rdata", int'(a_rdata), int'(e.data));
                        if (e.due >= 0) chk("a_ack_cycle", cyc, e.due);
                    end
                end
                if (b_ack) begin
                    if (q_b.size() == 0) chk("b_ack_pending", q_b.size(), 1);
                    else begin
                        e = q_b.pop_front();
                        chk("b_rdata", int'(b_rdata), int'(e.data));
                        if (e.due >= 0) chk("b_ack_cycle", cyc, e.due);
                    end
                end
                if (q_a.size() != 0 && cyc > q_a[0].issue + 6) begin
                    n_tot++;
                    $display("FAIL a_ack_timeout: waited %0d cycles, limit 6", cyc - q_a[0].issue);
                    void'(q_a.pop_front());
                end
                if (q_b.size() != 0 && cyc > q_b[0].issue + 6) begin
                    n_tot++;
                    $display("FAIL b_ack_timeout: waited %0d cycles, limit 6", cyc - q_b[0].issue);
                    void'(q_b.pop_front());
                end
            end
        end
    end

    // Reference model: a flat memory updated in grant order; lat < 0 means ack cycle unchecked.
    task automatic issue_a(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int lat);
        a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wd;
        q_a.push_back('{data: ref_mem[addr], issue: cyc, due: (lat < 0) ? -1 : cyc + lat});
        if (wr) ref_mem[addr] = wd;
    endtask

    task automatic issue_b(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int lat);
        b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wd;
        q_b.push_back('{data: ref_mem[addr], issue: cyc, due: (lat < 0) ? -1 : cyc + lat});
        if (wr) ref_mem[addr] = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a();
        for (int i = 0; i < 10; i++) begin
            if (a_ack) break;
            tick();
        end
        a_req = 1'b0;
    endtask

    task automatic wait_b();
        for (int i = 0; i < 10; i++) begin
            if (b_ack) break;
            tick();
        end
        b_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();
    endtask

    initial begin
        int ia, ib;
        do_reset();

        // Write then read back; write returns old contents.
        issue_a(1'b1, 4'd3, 4'h7, 2); wait_a(); tick();
        issue_a(1'b0, 4'd3, 4'h0, 2); wait_a(); tick();

        // Swap semantics on B.
        do_reset();
        issue_b(1'b1, 4'd5, 4'hA, 2); wait_b(); tick();
        issue_b(1'b1, 4'd5, 4'h3, 2); wait_b(); tick();

        // Same-address race: A wins the tie after reset, B reads the new value next slot.
        do_reset();
        issue_a(1'b1, 4'd9, 4'hF, 2);
        issue_b(1'b0, 4'd9, 4'h0, 3);
        wait_a(); wait_b(); tick();

        // Tie after reset, then continuous back-to-back reads alternating A, B.
        do_reset();
        issue_a(1'b1, 4'd1, 4'h5, 2);
        issue_b(1'b1, 4'd2, 4'h6, 3);
        wait_a(); wait_b(); tick(); tick();
        issue_a(1'b0, 4'd1, 4'h0, 2);
        issue_b(1'b0, 4'd2, 4'h0, 3);
        ia = 1; ib = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (a_ack) begin
                if (ia < 8) begin issue_a(1'b0, 4'd1, 4'h0, 2); ia++; end
                else a_req = 1'b0;
            end
            if (b_ack) begin
                if (ib < 8) begin issue_b(1'b0, 4'd2, 4'h0, 2); ib++; end
                else b_req = 1'b0;
            end
            if (ia == 8 && ib == 8 && !a_req && !b_req) break;
        end
        tick();

        // Random traffic; A uses the lower half of the file, B the upper half.
        for (int i = 0; i < 300; i++) begin
            tick();
            if (a_ack) a_req = 1'b0;
            if (b_ack) b_req = 1'b0;
            if (!a_req && $urandom_range(2) != 0)
                issue_a(1'($urandom_range(1)), {1'b0, 3'($urandom_range(7))}, 4'($urandom_range(15)), -1);
            if (!b_req && $urandom_range(2) != 0)
                issue_b(1'($urandom_range(1)), {1'b1, 3'($urandom_range(7))}, 4'($urandom_range(15)), -1);
        end
        for (int i = 0; i < 20 && (a_req || b_req); i++) begin
            tick();
            if (a_ack) a_req = 1'b0;
            if (b_ack) b_req = 1'b0;
        end
        repeat (3) tick();

        // Reset during SERV_A of a write: no ack, file cleared, A wins the first tie.
        a_req = 1'b1; a_wr = 1'b1; a_addr = 4'd4; a_wdata = 4'hE;
        tick();
        #2 rst = 1'b1;
        do_reset();
        issue_a(1'b0, 4'd4, 4'h0, 2);
        issue_b(1'b0, 4'd4, 4'h0, 3);
        wait_a(); wait_b();
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
